// File: rtl/fpu_arb_pkg.sv
// Shared types for the fpucadd arbiter: operand bundle, rounding mode and
// the tracking entry that rides alongside the adder pipeline.
package fpu_arb_pkg;

  localparam int FP_W     = 81;  // extended operand width of fpucadd
  localparam int ID_W     = 3;   // requester index width, covers up to 8 requesters
  localparam int TAGW_MAX = 16;  // tracking tag field; requester TAGW must not exceed it

  typedef logic [2:0] rmode_t;

  typedef struct packed {
    logic [FP_W-1:0] A;
    logic [FP_W-1:0] B;
    rmode_t          rmode;
    logic            isDBL;
  } fpu_op_t;

  typedef struct packed {
    logic                vld;
    logic [ID_W-1:0]     id;
    logic [TAGW_MAX-1:0] tag;
  } trk_t;

endpackage

// File: rtl/fpu_add_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves
// to winner+1 only when a grant is issued.
module rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [2*NREQ-1:0] rot;
  logic [ID_W:0]     sum;
  logic              found;

  // Rotate requests so the pointer sits at bit 0, take the first set bit,
  // then map the offset back to an absolute requester index.
  always_comb begin
    rot   = {req, req} >> ptr_q;
    found = 1'b0;
    sum   = {1'b0, ptr_q};
    for (int k = 0; k < NREQ; k++) begin
      if (!found && en && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (ID_W+1)'(k);
      end
    end
    if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
    gnt_id = found ? sum[ID_W-1:0] : '0;
    gnt    = '0;
    for (int i = 0; i < NREQ; i++) gnt[i] = found && (int'(sum) == i);
    ptr_d = ptr_q;
    if (found) ptr_d = (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + ID_W'(1);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one fixed-latency, non-stallable fpucadd among NREQ requesters.
// Grants one op per cycle round-robin, registers it onto the adder inputs and
// carries {valid, id, tag} down a shift register aligned with the adder
// latency so each result returns one-hot to its originator.
// Optional flush port and in-flight kill: define FPU_ARB_FLUSH_EN.
module fpu_add_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int TAGW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_A,
  input  logic [NREQ*FP_W-1:0] req_B,
  input  logic [NREQ*3-1:0]    req_rmode,
  input  logic [NREQ-1:0]      req_isDBL,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic                 issue_hold,
  output logic [FP_W-1:0]      fpu_A,
  output logic [FP_W-1:0]      fpu_B,
  output logic [2:0]           fpu_rmode,
  output logic                 fpu_isDBL,
  output logic                 fpu_en,
  input  logic [FP_W-1:0]      fpu_res,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]      rsp_res,
  output logic [TAGW-1:0]      rsp_tag
`ifdef FPU_ARB_FLUSH_EN
  ,
  input  logic                 flush
`endif
);

  logic flush_i;
`ifdef FPU_ARB_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic [ID_W-1:0] gnt_id;
  logic            xfer;
  fpu_op_t         op_sel, fpu_op_q, fpu_op_d;
  logic [TAGW-1:0] tag_sel;

  // Stage 0 is the issue register (concurrent with fpu_*); stage LAT lines up
  // with fpu_res for the same op.
  trk_t [LAT:0]    trk_q, trk_d;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [FP_W-1:0] rsp_res_q, rsp_res_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (!rst && !issue_hold && !flush_i),
    .gnt   (req_ready),
    .gnt_id(gnt_id)
  );

  assign xfer = |req_ready;

  // Select the winner's operands; grant is one-hot so an OR-mux suffices.
  always_comb begin
    op_sel  = '0;
    tag_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        op_sel.A     = req_A[i*FP_W +: FP_W];
        op_sel.B     = req_B[i*FP_W +: FP_W];
        op_sel.rmode = req_rmode[i*3 +: 3];
        op_sel.isDBL = req_isDBL[i];
        tag_sel      = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  // Next state: adder inputs hold when idle, tracking shifts every cycle,
  // response captures fpu_res only when the aligned tracking entry is live.
  always_comb begin
    fpu_op_d = xfer ? op_sel : fpu_op_q;

    trk_d[0].vld = xfer;
    trk_d[0].id  = gnt_id;
    trk_d[0].tag = TAGW_MAX'(tag_sel);
    for (int k = 1; k <= LAT; k++) trk_d[k] = trk_q[k-1];
    if (flush_i) begin
      for (int k = 0; k <= LAT; k++) trk_d[k].vld = 1'b0;
    end

    rsp_valid_d = '0;
    rsp_res_d   = rsp_res_q;
    rsp_tag_d   = rsp_tag_q;
    if (trk_q[LAT].vld && !flush_i) begin
      rsp_valid_d = NREQ'(1) << trk_q[LAT].id;
      rsp_res_d   = fpu_res;
      rsp_tag_d   = TAGW'(trk_q[LAT].tag);
    end
  end

  // Issue, tracking and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_op_q    <= '0;
      trk_q       <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_tag_q   <= '0;
    end else begin
      fpu_op_q    <= fpu_op_d;
      trk_q       <= trk_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign fpu_A     = fpu_op_q.A;
  assign fpu_B     = fpu_op_q.B;
  assign fpu_rmode = fpu_op_q.rmode;
  assign fpu_isDBL = fpu_op_q.isDBL;
  assign fpu_en    = !rst;
  // A response landing in a flush cycle is suppressed along with the rest.
  assign rsp_valid = rsp_valid_q & {NREQ{!flush_i}};
  assign rsp_res   = rsp_res_q;
  assign rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter: grant vectors from a table, expected
// responses from a scoreboard keyed on the cycle they must appear, and a
// stand-in fpucadd that adds raw operand bits with LAT cycles of delay.
module tb_fpu_add_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int TAGW = 6;
  localparam int W    = 81;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_A, req_B;
  logic [NREQ*3-1:0]    req_rmode;
  logic [NREQ-1:0]      req_isDBL;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 issue_hold;
  logic [W-1:0]         fpu_A, fpu_B, fpu_res;
  logic [2:0]           fpu_rmode;
  logic                 fpu_isDBL, fpu_en;
  logic [NREQ-1:0]      rsp_valid;
  logic [W-1:0]         rsp_res;
  logic [TAGW-1:0]      rsp_tag;
  logic                 flush = 1'b0;

  always #5 clk = ~clk;

  fpu_add_arbiter #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_rmode(req_rmode),
    .req_isDBL(req_isDBL), .req_tag(req_tag), .issue_hold(issue_hold),
    .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_rmode(fpu_rmode),
    .fpu_isDBL(fpu_isDBL), .fpu_en(fpu_en), .fpu_res(fpu_res),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_tag(rsp_tag)
`ifdef FPU_ARB_FLUSH_EN
    , .flush(flush)
`endif
  );

  // Stand-in adder: result of inputs registered at edge t is visible after edge t+LAT.
  logic [W-1:0] pipe [1:LAT];
  always @(posedge clk) begin
    pipe[1] <= fpu_A + fpu_B;
    for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign fpu_res = pipe[LAT];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-requester operand sources.
  logic [W-1:0]    a_v [NREQ];
  logic [W-1:0]    b_v [NREQ];
  logic [2:0]      rm_v[NREQ];
  logic            db_v[NREQ];
  logic [TAGW-1:0] tg_v[NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_A[g*W +: W]         = a_v[g];
    assign req_B[g*W +: W]         = b_v[g];
    assign req_rmode[g*3 +: 3]     = rm_v[g];
    assign req_isDBL[g]            = db_v[g];
    assign req_tag[g*TAGW +: TAGW] = tg_v[g];
  end

  typedef struct {
    int              due;
    logic [NREQ-1:0] oh;
    logic [W-1:0]    res;
    logic [TAGW-1:0] tag;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [NREQ-1:0] v;
    logic            h;
    logic [NREQ-1:0] rdy;
  } vec_t;
  vec_t tbl[18];

  logic [2*W+3:0] exp_fpu;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_all(input int k);
    for (int i = 0; i < NREQ; i++) begin
      a_v[i]  = W'(k*16 + i + 1);
      b_v[i]  = W'(i + 1) << 40;
      rm_v[i] = 3'(i);
      db_v[i] = (i % 2 == 1);
      tg_v[i] = TAGW'((k*4 + i) % 64);
    end
  endtask

  // One cycle: drive at negedge, check grant and due response, then cross the edge
  // and check what landed on the adder inputs.
  task automatic step(input logic [NREQ-1:0] v, input logic h, input logic fl,
                      input logic [NREQ-1:0] er);
    logic [NREQ-1:0] ev;
    logic [W-1:0]    eres;
    logic [TAGW-1:0] etag;
    int w;
    req_valid = v; issue_hold = h; flush = fl;
    #1;
    chk("req_ready", req_ready, er);
    if (fl) q.delete();
    ev = '0; eres = '0; etag = '0;
    for (int i = q.size()-1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        ev |= q[i].oh; eres = q[i].res; etag = q[i].tag;
        q.delete(i);
      end
    end
    chk("rsp_valid", rsp_valid, ev);
    if (ev != '0) begin
      chk("rsp_res", rsp_res, eres);
      chk("rsp_tag", rsp_tag, etag);
    end
    w = -1;
    for (int i = 0; i < NREQ; i++) if (er[i]) w = i;
    if (w >= 0) begin
      exp_fpu = {a_v[w], b_v[w], rm_v[w], db_v[w]};
      q.push_back('{cyc + 2 + LAT, er, a_v[w] + b_v[w], tg_v[w]});
    end
    @(posedge clk); @(negedge clk);
    chk("fpu_ops", {fpu_A, fpu_B, fpu_rmode, fpu_isDBL}, exp_fpu);
    chk("fpu_en", fpu_en, 1'b1);
  endtask

  task automatic reset_dut(input int n);
    req_valid = '1; issue_hold = 1'b0; flush = 1'b0; rst = 1'b1;
    #1;
    chk("ready_in_rst", req_ready, '0);
    chk("fpu_en_in_rst", fpu_en, 1'b0);
    q.delete();
    exp_fpu = '0;
    repeat (n) begin
      @(posedge clk); @(negedge clk);
      chk("rst_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_rsp_res", rsp_res, '0);
      chk("rst_rsp_tag", rsp_tag, '0);
      chk("rst_fpu_ops", {fpu_A, fpu_B, fpu_rmode, fpu_isDBL}, '0);
      chk("rst_fpu_en", fpu_en, 1'b0);
    end
    rst = 1'b0; req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Grant table, starting with pointer 0.
    tbl[0]  = '{4'hF, 1'b0, 4'h1};
    tbl[1]  = '{4'hF, 1'b0, 4'h2};
    tbl[2]  = '{4'hF, 1'b0, 4'h4};
    tbl[3]  = '{4'hF, 1'b0, 4'h8};
    tbl[4]  = '{4'hF, 1'b0, 4'h1};
    tbl[5]  = '{4'hF, 1'b0, 4'h2};
    tbl[6]  = '{4'hF, 1'b0, 4'h4};
    tbl[7]  = '{4'hF, 1'b0, 4'h8};
    tbl[8]  = '{4'hF, 1'b1, 4'h0};
    tbl[9]  = '{4'hF, 1'b1, 4'h0};
    tbl[10] = '{4'hF, 1'b1, 4'h0};
    tbl[11] = '{4'hF, 1'b0, 4'h1};
    tbl[12] = '{4'h4, 1'b0, 4'h4};
    tbl[13] = '{4'h3, 1'b0, 4'h1};
    tbl[14] = '{4'h0, 1'b0, 4'h0};
    tbl[15] = '{4'h9, 1'b0, 4'h8};
    tbl[16] = '{4'hA, 1'b0, 4'h2};
    tbl[17] = '{4'h2, 1'b0, 4'h2};

    set_all(0);
    exp_fpu = '0;
    reset_dut(2);

    // Single op from requester 2: 1.5 + 2.25 as raw Q.2 values 6 + 9 = 15 (3.75).
    while (cyc < 9) step('0, 1'b0, 1'b0, '0);
    a_v[2] = W'(6); b_v[2] = W'(9); rm_v[2] = 3'd2; db_v[2] = 1'b1; tg_v[2] = 6'h15;
    step(4'h4, 1'b0, 1'b0, 4'h4);
    while (cyc < 14) step('0, 1'b0, 1'b0, '0);
    chk("single_valid", rsp_valid, 4'b0100);
    chk("single_res", rsp_res, W'(15));
    chk("single_tag", rsp_tag, 6'h15);
    repeat (3) step('0, 1'b0, 1'b0, '0);

    // Three ops in flight (pointer is at 3), then reset drops them.
    set_all(1); step(4'hF, 1'b0, 1'b0, 4'h8);
    set_all(2); step(4'hF, 1'b0, 1'b0, 4'h1);
    set_all(3); step(4'hF, 1'b0, 1'b0, 4'h2);
    reset_dut(2);

    // Table: first grant after reset goes to requester 0.
    for (int k = 0; k < 18; k++) begin
      set_all(10 + k);
      step(tbl[k].v, tbl[k].h, 1'b0, tbl[k].rdy);
    end
    repeat (LAT + 3) step('0, 1'b0, 1'b0, '0);

    // Requester 1 alone, back to back.
    for (int k = 0; k < 8; k++) begin
      set_all(40 + k);
      step(4'h2, 1'b0, 1'b0, 4'h2);
    end
    repeat (LAT + 3) step('0, 1'b0, 1'b0, '0);

`ifdef FPU_ARB_FLUSH_EN
    // Two issues, flush, then one issue that must come back.
    set_all(60); step(4'h1, 1'b0, 1'b0, 4'h1);
    set_all(61); step(4'h2, 1'b0, 1'b0, 4'h2);
    set_all(62); step(4'hF, 1'b0, 1'b1, 4'h0);
    set_all(63); step(4'h4, 1'b0, 1'b0, 4'h4);
    repeat (LAT + 3) step('0, 1'b0, 1'b0, '0);
`endif

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one pipelined FP add unit (fpucadd, 81-bit extended operands, fixed LAT-cycle latency, non-stallable) between NREQ requesters.
- Round-robin grants at most one operation per cycle, registers the operands into the adder and tracks tag and requester ID alongside the pipeline.
- Steers each result back to its originator as a one-hot response.
- Sits between the scalar FP issue ports and the shared adder.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 3, fpucadd result latency in cycles from registered inputs to res
TAGW, 6, requester-private tag width, returned unchanged

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  NREQ  per-requester op valid
req_ready  out  NREQ  per-requester grant
req_A  in  NREQ*81  operand A, slice i = requester i
req_B  in  NREQ*81  operand B
req_rmode  in  NREQ*3  rounding mode
req_isDBL  in  NREQ  double-precision select
req_tag  in  NREQ*TAGW  op tag
issue_hold  in  1  blocks all new grants this cycle
fpu_A  out  81  to fpucadd A
fpu_B  out  81  to fpucadd B
fpu_rmode  out  3  to fpucadd rmode
fpu_isDBL  out  1  to fpucadd isDBL
fpu_en  out  1  to fpucadd en, constant 1 after reset
fpu_res  in  81  from fpucadd res
rsp_valid  out  NREQ  one-hot result valid
rsp_res  out  81  result
rsp_tag  out  TAGW  tag of result
flush  in  1  kill in-flight ops (present only with FPU_ARB_FLUSH_EN)

Behaviour:
- Reset is rst, synchronous, active-high.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_res=0, rsp_tag=0.
  - fpu_A, fpu_B, fpu_rmode, fpu_isDBL = 0.
  - fpu_en=0 during reset, 1 afterwards.
  - RR pointer=0; all pipeline valid bits cleared.
- Handshake:
  - An op transfers when req_valid[i] && req_ready[i] are high in the same cycle.
  - req_ready is combinational: at most one bit set.
  - req_ready may depend on req_valid.
  - req_ready is 0 whenever issue_hold=1 or rst=1.
- Arbitration:
  - Search starts at the RR pointer.
  - The first requester with valid set wins.
  - After a transfer, pointer = winner+1 mod NREQ.
  - No transfer: pointer unchanged.
  - A requester holding valid is granted within NREQ cycles, absent hold.
- Issue stage:
  - On transfer at edge t, winner operands, rmode and isDBL are registered onto fpu_*.
  - Registered {valid, requester ID, tag} enters a tracking shift register of depth LAT.
  - Without a transfer, fpu_* keep their previous values and the valid bit entered is 0.
- Response:
  - An op transferred at edge t produces rsp_valid[id]=1 for exactly the cycle following edge t+1+LAT.
  - In that cycle rsp_res = fpu_res and rsp_tag = the op's tag, both registered.
  - Responses are never stalled; requesters must sink one per cycle.
- Throughput: one op per cycle sustained; back-to-back results are allowed to the same or different requesters.
- Reset mid-operation: all in-flight ops are dropped; no rsp_valid after reset deasserts until new ops transfer.
- Simultaneous transfer and response to the same requester: both occur; they are independent.
- fpu_res is treated as don't-care in cycles whose tracking valid bit is 0; rsp_valid stays 0 then.

Optional Feature:
- FPU_ARB_FLUSH_EN defined:
  - flush port exists.
  - When flush=1, all tracking valid bits clear at the edge, including the op issued that cycle.
  - req_ready is forced 0 in the flush cycle.
  - rsp_valid is forced 0 in the flush cycle.
  - The RR pointer is unchanged.
- Not defined: no flush port; every accepted op always returns a response.

Decomposition:
- Package fpu_arb_pkg holds:
  - FP_W=81.
  - typedef rmode_t (3 bits).
  - typedef fpu_op_t {A, B, rmode, isDBL}.
  - Tracking-entry struct {vld, id, tag} parameterised via TAGW localparam.
- Sub-module rr_arbiter (NREQ req in, one-hot gate out, ptr update on accept) is natural and reusable.

Test Plan:
- Single op, requester 2:
  - Stimulus: A=1.5, B=2.25 (DBL, rmode=2), tag=0x15, accepted at edge 10.
  - Required: rsp_valid=4'b0100 for the one cycle following edge 14 (10+1+LAT), rsp_res=3.75, rsp_tag=0x15.
- All 4 requesters hold valid for 8 cycles, pointer=0:
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: responses in the same order, one per cycle, tags matching.
- issue_hold=1 for 3 cycles with requesters pending:
  - Required: req_ready=0 throughout, no fpu_* change, pointer held.
  - Required: grant resumes at the same requester.
- rst asserted with 3 ops in flight:
  - Required: no rsp_valid ever for them.
  - Required: next op after reset is granted to requester 0 and returns correctly.
- Requester 1 alone, continuous:
  - Required: ready every cycle, throughput 1/cycle.
  - Required: rsp_valid[1] high continuously from cycle LAT+1 on.
- FPU_ARB_FLUSH_EN, flush one cycle after 2 issues:
  - Required: neither op responds.
  - Required: an op issued the cycle after the flush responds normally.
